instruction_fetch_controller: RTL and testbench
===============================================

Name: instruction_fetch_controller

Overview:
Sequences the program counter into the byte-addressed, combinational-read instruction memory (4-byte little-endian word read at Inst_Address). Buffers fetched {pc, instruction} pairs in a small queue and delivers them to decode over a valid/ready handshake. Handles branch/jump redirects with a queue flush, end-of-image halt and misaligned-target error. Sits between the PC/branch logic and the IF/ID pipeline register.

Parameters:
IMEM_BYTES, 16, instruction memory size in bytes; the last legal fetch PC is IMEM_BYTES-4.
RESET_PC, 0, PC loaded on reset; must be 4-byte aligned.
QUEUE_DEPTH, 2, fetch queue entries; power of two, at least 2.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
Inst_Address  output  64  byte address driven to the instruction memory.
Instruction  input  32  word returned combinationally by the memory for Inst_Address.
redirect_valid  input  1  redirect request from branch/jump resolution.
redirect_pc  input  64  redirect target.
out_valid  output  1  queue head is valid.
out_ready  input  1  decode accepts the head this cycle.
out_instruction  output  32  head instruction.
out_pc  output  64  head PC.
halted  output  1  fetch stopped at end of image.
misaligned  output  1  sticky error: redirect target not 4-byte aligned.
fetch_count  output  32  count of instructions accepted by decode, wraps modulo 2^32.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - pc = RESET_PC, state = FETCH, queue empty;
  - out_valid = 0, out_instruction = 0, out_pc = 0;
  - halted = 0, misaligned = 0, fetch_count = 0.
- Inst_Address = pc, purely combinational from the pc register. Instruction is sampled in the same cycle.
- States:
  - FETCH:
    - If pc > IMEM_BYTES-4: no push; next state HALT; halted = 1 next cycle.
    - Else if the queue is not full, or is full and a pop occurs this cycle: push {pc, Instruction} and set pc = pc + 4.
    - Else (full, no pop): hold pc and do not push.
  - HALT: no fetch. Queued entries still drain to decode.
  - ERROR: no fetch. Queue is empty. Exit only by reset.
- Queue:
  - FIFO of QUEUE_DEPTH entries with registered head; out_* come directly from the head entry.
  - out_valid = (count != 0).
  - Pop when out_valid && out_ready; a pop increments fetch_count.
  - Push and pop in the same cycle are legal at any count (full included); count is unchanged.
  - When out_valid = 0, out_instruction and out_pc hold their last values and are don't-care to consumers.
  - Latency: an instruction fetched in cycle N is presented at out_* in cycle N+1 if the queue was empty.
- Redirect (redirect_valid = 1) has highest priority in FETCH and HALT and is ignored in ERROR:
  - The queue is flushed: count = 0 next cycle, and a pop in the same cycle is discarded.
  - No push occurs that cycle.
  - If redirect_pc[1:0] == 0: pc = redirect_pc, state = FETCH, halted = 0.
  - Otherwise: state = ERROR, misaligned = 1; pc is unchanged.
  - A redirect to pc > IMEM_BYTES-4 is accepted and enters HALT on the next FETCH evaluation.
- Widths and arithmetic:
  - pc is 64-bit and increments by 4 with natural 64-bit wrap.
  - The end-of-image comparison is unsigned.
- Reset asserted mid-operation overrides everything immediately: the queue is discarded and fetch_count is cleared.

Test Plan:
- Program image words 0x02853483, 0x009A84B3, 0x00148493, 0x02953423 at addresses 0/4/8/12; reset, then out_ready = 1 -> out_valid rises the cycle after reset deassert; out_pc/out_instruction sequence is 0/0x02853483, 4/0x009A84B3, 8/0x00148493, 12/0x02953423; then halted = 1 and fetch_count = 4.
- out_ready = 0 for 6 cycles after reset -> queue fills to 2 entries, Inst_Address holds at 8, out_pc stays 0; release out_ready -> delivery in order with no loss or duplicate.
- With entries 0 and 4 queued, redirect_valid = 1, redirect_pc = 12 while out_ready = 1 -> the cycle after, out_valid = 0 and fetch_count is unchanged; next head is pc 12 / 0x02953423.
- After halt (halted = 1), redirect_pc = 4 -> halted = 0 and fetch resumes with pc 4 / 0x009A84B3.
- redirect_pc = 6 -> misaligned = 1, out_valid = 0 thereafter; a further redirect to 0 is ignored; reset clears misaligned and restarts at pc 0.
- Assert reset asynchronously mid-fetch with 2 entries queued -> out_valid, halted and fetch_count go to 0 without waiting for a clock edge; Inst_Address = 0.

Source files
------------

// File: rtl/instruction_fetch_controller.sv
// Fetch sequencer: walks the PC through instruction memory and queues {pc, instruction} pairs for decode.
// One-cycle fetch-to-output latency when the queue is empty; a full queue with no pop holds the PC.
module instruction_fetch_controller #(
    parameter int          IMEM_BYTES  = 16,
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] Inst_Address,
    input  logic [31:0] Instruction,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [63:0] out_pc,
    output logic        halted,
    output logic        misaligned,
    output logic [31:0] fetch_count
);
    localparam int          CW      = $clog2(QUEUE_DEPTH + 1);
    localparam int          QW      = $clog2(QUEUE_DEPTH);
    localparam logic [63:0] LAST_PC = 64'(IMEM_BYTES - 4);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef enum logic [1:0] {FETCH, HALT, ERROR} state_t;

    state_t        state;
    logic [63:0]   pc;
    logic [CW-1:0] count;
    entry_t        q     [QUEUE_DEPTH];
    entry_t        q_nxt [QUEUE_DEPTH];
    logic          flush;
    logic          pop;
    logic          push;
    logic [QW-1:0] widx;

    assign Inst_Address    = pc;
    assign out_valid       = (count != '0);
    assign out_pc          = q[0].pc;
    assign out_instruction = q[0].instr;

    // Entry 0 is the head; a pop shifts occupied entries down, a push lands just past the survivors.
    // Slots that are not overwritten keep their contents so the head holds its last value when empty.
    always_comb begin
        flush = redirect_valid && (state != ERROR);
        pop   = out_valid && out_ready && !flush;
        push  = !flush && (state == FETCH) && (pc <= LAST_PC) &&
                ((count != CW'(QUEUE_DEPTH)) || pop);
        widx  = QW'(count - CW'(pop));
        q_nxt = q;
        for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
            if (pop && (CW'(i + 1) < count)) begin
                q_nxt[i] = q[i + 1];
            end
        end
        if (push) begin
            q_nxt[widx] = '{pc: pc, instr: Instruction};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            count       <= '0;
            halted      <= 1'b0;
            misaligned  <= 1'b0;
            fetch_count <= 32'd0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            q <= q_nxt;
            if (flush) begin
                count <= '0;
                if (redirect_pc[1:0] == 2'b00) begin
                    pc     <= redirect_pc;
                    state  <= FETCH;
                    halted <= 1'b0;
                end else begin
                    state      <= ERROR;
                    misaligned <= 1'b1;
                end
            end else begin
                count <= count + CW'(push) - CW'(pop);
                if (pop) begin
                    fetch_count <= fetch_count + 32'd1;
                end
                if (push) begin
                    pc <= pc + 64'd4;
                end
                if ((state == FETCH) && (pc > LAST_PC)) begin
                    state  <= HALT;
                    halted <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller: directed vector table, hand sequences, and a random run against a queue model.
module tb_instruction_fetch_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] inst_address;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [63:0] out_pc;
    logic        halted;
    logic        misaligned;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] words [4];
    logic [7:0]  imem  [16];

    always #5 clk = ~clk;

    // Little-endian byte memory, combinational read; out-of-image reads return zero.
    always_comb begin
        logic [3:0] a;
        a = inst_address[3:0];
        instruction = 32'd0;
        if (inst_address < 64'd16) begin
            instruction = {imem[a + 4'd3], imem[a + 4'd2], imem[a + 4'd1], imem[a]};
        end
    end

    instruction_fetch_controller #(
        .IMEM_BYTES (16),
        .RESET_PC   (64'd0),
        .QUEUE_DEPTH(2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .Inst_Address   (inst_address),
        .Instruction    (instruction),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instruction(out_instruction),
        .out_pc         (out_pc),
        .halted         (halted),
        .misaligned     (misaligned),
        .fetch_count    (fetch_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit check_vals);
        reset          = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        tick();
        if (check_vals) begin
            chk("rst_valid", out_valid, 0);
            chk("rst_pc", out_pc, 0);
            chk("rst_instr", out_instruction, 0);
            chk("rst_halted", halted, 0);
            chk("rst_misaligned", misaligned, 0);
            chk("rst_count", fetch_count, 0);
            chk("rst_addr", inst_address, 0);
        end
        reset = 1'b0;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_pc;
    int          m_mode;  // 0 fetching, 1 halted, 2 error
    logic        m_halt;
    logic        m_mis;
    logic [31:0] m_cnt;

    function automatic logic [31:0] word_at(input logic [63:0] a);
        if (a < 64'd16) return words[int'(a[3:2])];
        return 32'd0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc   = 64'd0;
        m_mode = 0;
        m_halt = 1'b0;
        m_mis  = 1'b0;
        m_cnt  = 32'd0;
    endtask

    task automatic model_step(input logic rdy, input logic rv, input logic [63:0] rpc);
        ent_t e;
        if (rv && m_mode != 2) begin
            mq.delete();
            if (rpc[1:0] == 2'b00) begin
                m_pc   = rpc;
                m_mode = 0;
                m_halt = 1'b0;
            end else begin
                m_mode = 2;
                m_mis  = 1'b1;
            end
        end else begin
            if (rdy && mq.size() > 0) begin
                void'(mq.pop_front());
                m_cnt = m_cnt + 32'd1;
            end
            if (m_mode == 0) begin
                if (m_pc > 64'd12) begin
                    m_mode = 1;
                    m_halt = 1'b1;
                end else if (mq.size() < 2) begin
                    e.pc  = m_pc;
                    e.ins = word_at(m_pc);
                    mq.push_back(e);
                    m_pc = m_pc + 64'd4;
                end
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rdy;
        logic        rv;
        logic [63:0] rpc;
        logic        e_vld;
        logic [63:0] e_pc;
        logic [31:0] e_ins;
        logic        e_halt;
        logic        e_mis;
        logic [31:0] e_cnt;
        logic [63:0] e_addr;
    } vec_t;

    vec_t vt [10];

    initial begin
        logic [63:0] got_pc  [4];
        logic [31:0] got_ins [4];
        int          got;
        logic [63:0] opts [7];

        #200_000_000;
        $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got_pc  [4];
        logic [31:0] got_ins [4];
        int          got;
        logic [63:0] opts [7];

        words[0] = 32'h02853483;
        words[1] = 32'h009A84B3;
        words[2] = 32'h00148493;
        words[3] = 32'h02953423;
        for (int i = 0; i < 16; i++) imem[i] = words[i / 4][8 * (i % 4) +: 8];

        //          rdy  rv   rpc    vld  pc     ins            halt mis cnt  addr
        vt[0] = '{1'b1, 1'b0, 64'd0, 1'b0, 64'd0,  32'h0,        1'b0, 1'b0, 32'd0, 64'd0};
        vt[1] = '{1'b1, 1'b0, 64'd0, 1'b1, 64'd0,  32'h02853483, 1'b0, 1'b0, 32'd0, 64'd4};
        vt[2] = '{1'b1, 1'b0, 64'd0, 1'b1, 64'd4,  32'h009A84B3, 1'b0, 1'b0, 32'd1, 64'd8};
        vt[3] = '{1'b1, 1'b0, 64'd0, 1'b1, 64'd8,  32'h00148493, 1'b0, 1'b0, 32'd2, 64'd12};
        vt[4] = '{1'b1, 1'b0, 64'd0, 1'b1, 64'd12, 32'h02953423, 1'b0, 1'b0, 32'd3, 64'd16};
        vt[5] = '{1'b1, 1'b1, 64'd4, 1'b0, 64'd0,  32'h0,        1'b1, 1'b0, 32'd4, 64'd16};
        vt[6] = '{1'b1, 1'b0, 64'd0, 1'b0, 64'd0,  32'h0,        1'b0, 1'b0, 32'd4, 64'd4};
        vt[7] = '{1'b1, 1'b1, 64'd6, 1'b1, 64'd4,  32'h009A84B3, 1'b0, 1'b0, 32'd4, 64'd8};
        vt[8] = '{1'b1, 1'b1, 64'd0, 1'b0, 64'd0,  32'h0,        1'b0, 1'b1, 32'd4, 64'd8};
        vt[9] = '{1'b1, 1'b0, 64'd0, 1'b0, 64'd0,  32'h0,        1'b0, 1'b1, 32'd4, 64'd8};

        reset          = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        do_reset(1);

        for (int r = 0; r < 10; r++) begin
            out_ready      = vt[r].rdy;
            redirect_valid = vt[r].rv;
            redirect_pc    = vt[r].rpc;
            chk($sformatf("vec%0d_valid", r), out_valid, vt[r].e_vld);
            if (vt[r].e_vld) begin
                chk($sformatf("vec%0d_pc", r), out_pc, vt[r].e_pc);
                chk($sformatf("vec%0d_instr", r), out_instruction, vt[r].e_ins);
            end
            chk($sformatf("vec%0d_halted", r), halted, vt[r].e_halt);
            chk($sformatf("vec%0d_misaligned", r), misaligned, vt[r].e_mis);
            chk($sformatf("vec%0d_count", r), fetch_count, vt[r].e_cnt);
            chk($sformatf("vec%0d_addr", r), inst_address, vt[r].e_addr);
            tick();
        end

        // Reset clears the sticky error and fetch restarts at 0.
        do_reset(1);
        tick();
        chk("restart_valid", out_valid, 1);
        chk("restart_pc", out_pc, 0);

        // Backpressure: queue fills, PC parks at 8, then drains in order.
        do_reset(0);
        for (int c = 0; c < 6; c++) begin
            if (c >= 2) begin
                chk($sformatf("bp_hold%0d_addr", c), inst_address, 8);
                chk($sformatf("bp_hold%0d_pc", c), out_pc, 0);
                chk($sformatf("bp_hold%0d_valid", c), out_valid, 1);
            end
            tick();
        end
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (out_valid) begin
                got_pc[got]  = out_pc;
                got_ins[got] = out_instruction;
                got++;
            end
            tick();
        end
        chk("bp_delivered", got, 4);
        for (int i = 0; i < got; i++) begin
            chk($sformatf("bp_order%0d_pc", i), got_pc[i], 64'(4 * i));
            chk($sformatf("bp_order%0d_instr", i), got_ins[i], words[i]);
        end
        chk("bp_halted", halted, 1);
        chk("bp_count", fetch_count, 4);
        chk("bp_empty", out_valid, 0);

        // Redirect with two entries queued and a pop offered: flush wins.
        do_reset(0);
        tick();
        tick();
        chk("flush_pre_valid", out_valid, 1);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'd12;
        tick();
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_count", fetch_count, 0);
        chk("flush_addr", inst_address, 12);
        tick();
        chk("flush_next_valid", out_valid, 1);
        chk("flush_next_pc", out_pc, 12);
        chk("flush_next_instr", out_instruction, 32'h02953423);

        // Asynchronous reset between clock edges with a full queue.
        do_reset(0);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        chk("arst_pre_valid", out_valid, 1);
        chk("arst_pre_count", fetch_count, 1);
        chk("arst_pre_addr", inst_address, 12);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_halted", halted, 0);
        chk("arst_count", fetch_count, 0);
        chk("arst_addr", inst_address, 0);

        // Random run against the model.
        opts[0] = 64'd0;
        opts[1] = 64'd4;
        opts[2] = 64'd8;
        opts[3] = 64'd12;
        opts[4] = 64'd16;
        opts[5] = 64'd20;
        opts[6] = 64'hFFFF_FFFF_FFFF_FFFC;
        for (int seg = 0; seg < 12; seg++) begin
            do_reset(0);
            model_reset();
            for (int c = 0; c < 250; c++) begin
                out_ready      = ($urandom_range(3) != 0);
                redirect_valid = ($urandom_range(7) == 0);
                redirect_pc    = opts[$urandom_range(6)];
                if ($urandom_range(99) < 4) redirect_pc = redirect_pc | 64'(1 + $urandom_range(2));
                chk("rnd_valid", out_valid, mq.size() != 0);
                if (mq.size() != 0) begin
                    chk("rnd_pc", out_pc, mq[0].pc);
                    chk("rnd_instr", out_instruction, mq[0].ins);
                end
                chk("rnd_halted", halted, m_halt);
                chk("rnd_misaligned", misaligned, m_mis);
                chk("rnd_count", fetch_count, m_cnt);
                chk("rnd_addr", inst_address, m_pc);
                model_step(out_ready, redirect_valid, redirect_pc);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
